shift_tx_ctrl: RTL and testbench

Serializing controller for the team's parallel-load shift datapath. Accepts WIDTH-bit words over a valid/ready handshake, loads each word into an internal parallel-in/serial-out register and shifts it out MSB-first, one bit per clock. Adds frame start/done strobes and a programmable idle gap between frames. Sits between a word producer and any bit-serial consumer (serial link, test pattern output).

---
 rtl/shift_pkg.sv | 15 +
 rtl/piso_reg.sv | 25 ++
 rtl/shift_tx_ctrl.sv | 89 ++++++++
 tb/tb_shift_tx_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift_tx_ctrl serializer: FSM encoding,
// default geometry and the idle-gap counter width.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 1;
    localparam int GAP_CW    = 4;

endpackage

// File: rtl/piso_reg.sv
// Parallel-in/serial-out register: parallel load, left shift with zero fill.
// Load takes priority over shift_en.
module piso_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_tx_ctrl.sv
// Word-to-serial controller: accepts a word on a valid/ready handshake, shifts
// it out MSB-first with frame strobes, then idles GAP cycles before the next word.
module shift_tx_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [GAP_CW-1:0] gap_cnt;
    logic [WIDTH-1:0]  sreg;
    logic              load;
    logic              shift_en;

    // Reset inside piso_reg overrides load, so no rst term is needed here.
    assign load     = (state == ST_IDLE) && in_valid;
    assign shift_en = (state == ST_SHIFT);

    piso_reg #(.WIDTH(WIDTH)) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .d        (in_data),
        .q        (sreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        if (GAP > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; in_ready alone also sees rst.
    assign in_ready    = (state == ST_IDLE) && !rst;
    assign sout_valid  = (state == ST_SHIFT);
    assign sout        = sout_valid && sreg[WIDTH-1];
    assign frame_start = sout_valid && (bit_cnt == '0);
    assign frame_done  = sout_valid && (bit_cnt == LAST_BIT);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench for shift_tx_ctrl: three instances (W4/G1, W4/G0, W8/G1) checked every
// cycle against a timing-based reference model, directed cases then random traffic.
module tb_shift_tx_ctrl;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] in_valid;
    logic [7:0] data [3];
    wire  [2:0] in_ready, sout, sout_valid, frame_start, frame_done, busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: a frame is "age" edges old; outputs follow from the timing rules.
    bit          active [3];
    int          age    [3];
    logic [31:0] word   [3];
    bit          hs     [3];

    shift_tx_ctrl #(.WIDTH(4), .GAP(1)) u_w4g1 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(data[0][3:0]),
        .in_ready(in_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
        .frame_start(frame_start[0]), .frame_done(frame_done[0]), .busy(busy[0]));

    shift_tx_ctrl #(.WIDTH(4), .GAP(0)) u_w4g0 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(data[1][3:0]),
        .in_ready(in_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
        .frame_start(frame_start[1]), .frame_done(frame_done[1]), .busy(busy[1]));

    shift_tx_ctrl #(.WIDTH(8), .GAP(1)) u_w8g1 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_data(data[2]),
        .in_ready(in_ready[2]), .sout(sout[2]), .sout_valid(sout_valid[2]),
        .frame_start(frame_start[2]), .frame_done(frame_done[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid_of(int i);
        return (i == 2) ? 8 : 4;
    endfunction

    function automatic int gap_of(int i);
        return (i == 1) ? 0 : 1;
    endfunction

    // {in_ready, busy, frame_done, frame_start, sout_valid, sout}
    function automatic logic [5:0] model_out(int i);
        int   k = age[i];
        logic shifting, bsy, s;
        shifting = active[i] && (k < wid_of(i));
        bsy      = active[i] && (k < wid_of(i) + gap_of(i));
        s        = shifting ? word[i][wid_of(i) - 1 - k] : 1'b0;
        return {!rst[i] && !bsy, bsy, shifting && (k == wid_of(i) - 1),
                shifting && (k == 0), shifting, s};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model at the rising edge, compare all outputs at the falling edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            bit ready_pre;
            ready_pre = !rst[i] && !(active[i] && age[i] < wid_of(i) + gap_of(i));
            hs[i] = 1'b0;
            if (rst[i]) begin
                active[i] = 1'b0;
            end else if (ready_pre && in_valid[i]) begin
                active[i] = 1'b1;
                age[i]    = 0;
                word[i]   = 32'(data[i]);
                hs[i]     = 1'b1;
            end else if (active[i]) begin
                age[i]++;
            end
        end
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("outs_inst%0d_cyc%0d", i, cyc),
                  32'({in_ready[i], busy[i], frame_done[i], frame_start[i],
                       sout_valid[i], sout[i]}),
                  32'(model_out(i)));
        end
    endtask

    task automatic steps(int n);
        for (int j = 0; j < n; j++) step();
    endtask

    // Step until instance i handshakes; n is the number of edges taken.
    task automatic wait_hs(int i, int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!hs[i] && n < budget);
        check($sformatf("hs_in_budget_inst%0d_cyc%0d", i, cyc), 32'(hs[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int busy_cycles;
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0;
            age[i]    = 0;
            word[i]   = '0;
            hs[i]     = 1'b0;
            data[i]   = '0;
        end
        rst      = 3'b111;
        in_valid = 3'b000;
        steps(2);

        // Single word on each instance; W4G0 gets 0001 held for two frames.
        rst     = 3'b000;
        data[0] = 8'h0A; in_valid[0] = 1'b1;
        data[1] = 8'h01; in_valid[1] = 1'b1;
        data[2] = 8'hA5; in_valid[2] = 1'b1;
        step();
        check("w4g0_first_hs", 32'(hs[1]), 32'd1);
        in_valid[0] = 1'b0;
        in_valid[2] = 1'b0;
        busy_cycles = 0;
        for (int j = 0; j < 12; j++) begin
            if (j == 0) busy_cycles += int'(busy[2]);
            step();
            busy_cycles += int'(busy[2]);
            if (hs[1]) begin
                check("w4g0_hs_spacing", 32'(j + 1), 32'd5);
                in_valid[1] = 1'b0;
            end
        end
        check("w8_busy_cycles", 32'(busy_cycles), 32'd9);

        // Back-to-back words: 1010 then 1111 with in_valid held.
        data[0] = 8'h0A; in_valid[0] = 1'b1;
        wait_hs(0, 10, n);
        data[0] = 8'h0F;
        wait_hs(0, 20, n);
        check("b2b_hs_spacing", 32'(n), 32'd6);
        in_valid[0] = 1'b0;
        steps(6);

        // Input change while busy: 0101 must wait for the next IDLE.
        data[0] = 8'h0A; in_valid[0] = 1'b1;
        wait_hs(0, 10, n);
        data[0] = 8'h05;
        wait_hs(0, 20, n);
        check("busy_change_hs_spacing", 32'(n), 32'd6);
        check("busy_change_word", word[0], 32'h5);
        in_valid[0] = 1'b0;
        steps(6);

        // Reset after the second bit of 1010, then 0110 transmits normally.
        data[0] = 8'h0A; in_valid[0] = 1'b1;
        wait_hs(0, 10, n);
        in_valid[0] = 1'b0;
        step();
        rst[0] = 1'b1;
        step();
        check("rst_mid_no_done", 32'(frame_done[0]), 32'd0);
        rst[0] = 1'b0;
        data[0] = 8'h06; in_valid[0] = 1'b1;
        wait_hs(0, 5, n);
        check("rst_then_immediate_hs", 32'(n), 32'd1);
        in_valid[0] = 1'b0;
        steps(7);

        // Random traffic with occasional resets on all three instances.
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                data[i]     = 8'($urandom);
                rst[i]      = ($urandom_range(0, 40) == 0);
            end
            step();
        end
        rst      = 3'b000;
        in_valid = 3'b000;
        steps(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
